// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane-potential integrator: one forward-Euler step per start, one shared multiplier.
// Optional upward threshold-crossing spike detector enabled by defining HH_SPIKE_DETECT_EN.
module hh_membrane_update #(
  parameter int G_NA    = 120,
  parameter int G_K     = 36,
  parameter int G_L_X10 = 3,
  parameter int E_NA    = 5000,
  parameter int E_K     = -7700,
  parameter int E_L     = -5440,
  parameter int V_REST  = -6500,
  parameter int V_SPIKE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        m_in,
  input  logic [15:0]        h_in,
  input  logic [15:0]        n_in,
  input  logic signed [15:0] i_ext,
  input  logic [15:0]        dt,
  output logic signed [15:0] v_out,
  output logic               busy,
  output logic               done,
  output logic               spike
);

  typedef logic signed [47:0] wide_t;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_M2    = 4'd2,
    S_M3    = 4'd3,
    S_M3H   = 4'd4,
    S_N2    = 4'd5,
    S_N4    = 4'd6,
    S_INA   = 4'd7,
    S_IK    = 4'd8,
    S_ILEAK = 4'd9,
    S_EULER = 4'd10
  } state_t;

  localparam wide_t G_NA_W    = wide_t'(G_NA);
  localparam wide_t G_K_W     = wide_t'(G_K);
  localparam wide_t G_L_X10_W = wide_t'(G_L_X10);
  localparam wide_t E_NA_W    = wide_t'(E_NA);
  localparam wide_t E_K_W     = wide_t'(E_K);
  localparam wide_t E_L_W     = wide_t'(E_L);
  localparam logic signed [15:0] V_REST_16 = 16'(V_REST);

  function automatic logic [15:0] clamp_gate(input logic [15:0] x);
    logic [15:0] r;
    if (x > 16'd1000) r = 16'd1000;
    else              r = x;
    return r;
  endfunction

  function automatic logic signed [15:0] sat16(input wide_t x);
    logic signed [15:0] r;
    if (x > 48'sd32767)       r = 16'sh7fff;
    else if (x < -48'sd32768) r = 16'sh8000;
    else                      r = x[15:0];
    return r;
  endfunction

  state_t             state_r, state_s;
  logic [15:0]        m_r, h_r, n_r, dt_r;
  logic signed [15:0] iext_r;
  logic signed [15:0] v_out_r;
  logic               busy_r, done_r;
  wide_t              dna_r, dk_r, dl_r;
  wide_t              t1_r, t2_r, dv_r;
  wide_t              mul_a_s, mul_b_s, prod_s, vn_s;
  logic signed [15:0] vn_sat_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic: fixed sequence, start only honoured in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_LOAD;
        else       state_s = S_IDLE;
      end
      S_LOAD:  state_s = S_M2;
      S_M2:    state_s = S_M3;
      S_M3:    state_s = S_M3H;
      S_M3H:   state_s = S_N2;
      S_N2:    state_s = S_N4;
      S_N4:    state_s = S_INA;
      S_INA:   state_s = S_IK;
      S_IK:    state_s = S_ILEAK;
      S_ILEAK: state_s = S_EULER;
      S_EULER: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Shared multiplier operand selection
  always_comb begin
    mul_a_s = 48'sd0;
    mul_b_s = 48'sd0;
    case (state_r)
      S_M2:    begin mul_a_s = wide_t'(m_r);  mul_b_s = wide_t'(m_r);  end
      S_M3:    begin mul_a_s = t1_r;          mul_b_s = wide_t'(m_r);  end
      S_M3H:   begin mul_a_s = t1_r;          mul_b_s = wide_t'(h_r);  end
      S_N2:    begin mul_a_s = wide_t'(n_r);  mul_b_s = wide_t'(n_r);  end
      S_N4:    begin mul_a_s = t2_r;          mul_b_s = t2_r;          end
      S_INA:   begin mul_a_s = t1_r;          mul_b_s = dna_r;         end
      S_IK:    begin mul_a_s = t2_r;          mul_b_s = dk_r;          end
      S_ILEAK: begin mul_a_s = G_L_X10_W;     mul_b_s = dl_r;          end
      S_EULER: begin mul_a_s = dv_r;          mul_b_s = wide_t'(dt_r); end
      default: begin mul_a_s = 48'sd0;        mul_b_s = 48'sd0;        end
    endcase
  end

  assign prod_s   = mul_a_s * mul_b_s;
  assign vn_s     = wide_t'(v_out_r) + prod_s / 48'sd1000;
  assign vn_sat_s = sat16(vn_s);

  // Datapath: capture, per-state scaling of the product, write-back of V
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r     <= 16'd0;
      h_r     <= 16'd0;
      n_r     <= 16'd0;
      dt_r    <= 16'd0;
      iext_r  <= 16'sd0;
      v_out_r <= V_REST_16;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dna_r   <= 48'sd0;
      dk_r    <= 48'sd0;
      dl_r    <= 48'sd0;
      t1_r    <= 48'sd0;
      t2_r    <= 48'sd0;
      dv_r    <= 48'sd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r    <= clamp_gate(m_in);
            h_r    <= clamp_gate(h_in);
            n_r    <= clamp_gate(n_in);
            iext_r <= i_ext;
            dt_r   <= dt;
            busy_r <= 1'b1;
          end
        end
        // v_out only moves at write-back, so it doubles as the captured V
        S_LOAD: begin
          dna_r <= wide_t'(v_out_r) - E_NA_W;
          dk_r  <= wide_t'(v_out_r) - E_K_W;
          dl_r  <= wide_t'(v_out_r) - E_L_W;
        end
        S_M2, S_M3, S_M3H: t1_r <= prod_s / 48'sd1000;
        S_N2, S_N4:        t2_r <= prod_s / 48'sd1000;
        S_INA:   dv_r <= wide_t'(iext_r) - (prod_s * G_NA_W) / 48'sd1000;
        S_IK:    dv_r <= dv_r - (prod_s * G_K_W) / 48'sd1000;
        S_ILEAK: dv_r <= dv_r - prod_s / 48'sd10;
        S_EULER: begin
          v_out_r <= vn_sat_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HH_SPIKE_DETECT_EN
  localparam logic signed [15:0] V_SPIKE_16 = 16'(V_SPIKE);
  logic spike_r;

  // Spike pulse on an upward crossing of the threshold, aligned with done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  spike_r <= 1'b0;
    else if (state_r == S_EULER) spike_r <= (v_out_r < V_SPIKE_16) && (vn_sat_s >= V_SPIKE_16);
    else                         spike_r <= 1'b0;
  end

  assign spike = spike_r;
`else
  assign spike = 1'b0;
`endif

  assign v_out = v_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule
